// File: rtl/btn_conditioner.sv
// btn_conditioner: multi-channel button synchroniser, debouncer, edge and long-press/auto-repeat pulse generator
// Ports:
//   clk, rst     - system clock, asynchronous active-high reset
//   tick         - shared single-cycle timing strobe for hold timing
//   btn          - raw asynchronous button levels, one bit per channel
//   btn_level    - debounced level per channel
//   btn_press    - 1-cycle pulse on debounced rise
//   btn_release  - 1-cycle pulse on debounced fall
//   btn_long     - 1-cycle pulse when a hold reaches LONG_TICKS ticks
//   btn_repeat   - 1-cycle pulse every REPEAT_TICKS ticks after a long press
module btn_conditioner #(
  parameter int WIDTH        = 4,
  parameter int DB_CYCLES    = 1000000,
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_TICKS = 200,
  parameter int REPEAT_EN    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic [WIDTH-1:0] btn,
  output logic [WIDTH-1:0] btn_level,
  output logic [WIDTH-1:0] btn_press,
  output logic [WIDTH-1:0] btn_release,
  output logic [WIDTH-1:0] btn_long,
  output logic [WIDTH-1:0] btn_repeat
);
  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam int HMAX = LONG_TICKS > REPEAT_TICKS ? LONG_TICKS : REPEAT_TICKS;
  localparam int HW = $clog2(HMAX + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_TICKS - 1);
  localparam logic [HW-1:0] REP_LAST = HW'(REPEAT_TICKS - 1);
  typedef enum logic [1:0] {IDLE, HELD, REPEAT} hold_t;
  genvar i;
  for (i = 0; i < WIDTH; i++) begin : g_ch
    logic sync0, sync1, level, press, rel, lng, rep;
    logic [CW-1:0] db_cnt;
    logic [HW-1:0] hold_cnt;
    hold_t state;
    logic flip, rise, fall;
    // flip marks the edge on which the debounced level takes the synchronised value
    assign flip = (sync1 != level) && (db_cnt == DB_LAST);
    assign rise = flip & sync1;
    assign fall = flip & ~sync1;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync0 <= 1'b0;
        sync1 <= 1'b0;
        level <= 1'b0;
        db_cnt <= '0;
        press <= 1'b0;
        rel <= 1'b0;
        lng <= 1'b0;
        rep <= 1'b0;
        hold_cnt <= '0;
        state <= IDLE;
      end else begin
        sync0 <= btn[i];
        sync1 <= sync0;
        db_cnt <= (sync1 == level || flip) ? '0 : db_cnt + CW'(1);
        if (flip) level <= sync1;
        press <= rise;
        rel <= fall;
        lng <= 1'b0;
        rep <= 1'b0;
        // a fall always wins over a coincident tick, so no long/repeat pulse that cycle
        if (fall) begin
          state <= IDLE;
          hold_cnt <= '0;
        end else begin
          case (state)
            IDLE: if (rise) begin
              state <= HELD;
              hold_cnt <= '0;
            end
            HELD: if (tick) begin
              if (hold_cnt == LONG_LAST) begin
                lng <= 1'b1;
                hold_cnt <= '0;
                state <= REPEAT;
              end else hold_cnt <= hold_cnt + HW'(1);
            end
            REPEAT: if (tick) begin
              if (hold_cnt == REP_LAST) begin
                rep <= (REPEAT_EN != 0);
                hold_cnt <= '0;
              end else hold_cnt <= hold_cnt + HW'(1);
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
    assign btn_level[i] = level;
    assign btn_press[i] = press;
    assign btn_release[i] = rel;
    assign btn_long[i] = lng;
    assign btn_repeat[i] = rep;
  end
endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: directed self-checking bench for btn_conditioner
module tb_btn_conditioner;
  logic clk = 1'b0;
  logic rst, tick;
  logic [1:0] btn, level, press, rel, lng, rep;
  logic [1:0] nlevel, npress, nrel, nlng, nrep;
  int total = 0, bad = 0, e = 0, e0, r;
  int pc[2], rc[2], lc[2], qc[2], nlc[2], nqc[2], pe[2], re[2], le[2], qf[2];
  bit tick_auto;

  always #5 clk = ~clk;

  btn_conditioner #(.WIDTH(2), .DB_CYCLES(4), .LONG_TICKS(3), .REPEAT_TICKS(2), .REPEAT_EN(1)) dut (
    .clk(clk), .rst(rst), .tick(tick), .btn(btn),
    .btn_level(level), .btn_press(press), .btn_release(rel), .btn_long(lng), .btn_repeat(rep)
  );

  btn_conditioner #(.WIDTH(2), .DB_CYCLES(4), .LONG_TICKS(3), .REPEAT_TICKS(2), .REPEAT_EN(0)) dut_nr (
    .clk(clk), .rst(rst), .tick(tick), .btn(btn),
    .btn_level(nlevel), .btn_press(npress), .btn_release(nrel), .btn_long(nlng), .btn_repeat(nrep)
  );

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task clr();
    for (int c = 0; c < 2; c++) begin
      pc[c] = 0; rc[c] = 0; lc[c] = 0; qc[c] = 0; nlc[c] = 0; nqc[c] = 0;
      pe[c] = -1; re[c] = -1; le[c] = -1; qf[c] = -1;
    end
  endtask

  // ticks land on edges that are multiples of 10; pulses are tallied after each edge
  task cycle();
    tick = tick_auto && ((e + 1) % 10 == 0);
    @(posedge clk);
    e++;
    #1;
    for (int c = 0; c < 2; c++) begin
      if (press[c]) begin pc[c]++; pe[c] = e; end
      if (rel[c]) begin rc[c]++; re[c] = e; end
      if (lng[c]) begin lc[c]++; le[c] = e; end
      if (rep[c]) begin if (qc[c] == 0) qf[c] = e; qc[c]++; end
      if (nlng[c]) nlc[c]++;
      if (nrep[c]) nqc[c]++;
    end
  endtask

  task run(input int n);
    repeat (n) cycle();
  endtask

  task align();
    while (e % 10 != 0) cycle();
  endtask

  initial begin
    rst = 1'b1; btn = 2'b00; tick = 1'b0; tick_auto = 1'b1;
    clr();
    run(3);
    chk("reset_outs", int'({level, press, rel, lng, rep, nlevel, npress, nrel, nlng, nrep}), 0);
    rst = 1'b0;
    run(5);
    chk("idle_outs", int'({level, press, rel, lng, rep}), 0);

    // clean press on channel 0, held 20 clk
    align(); clr(); e0 = e; btn = 2'b01;
    run(5);
    chk("cp_level_early", int'(level[0]), 0);
    cycle();
    chk("cp_level_rise", int'(level[0]), 1);
    chk("cp_press_on", int'(press[0]), 1);
    cycle();
    chk("cp_press_off", int'(press[0]), 0);
    run(13);
    chk("cp_ch1_quiet", int'(level[1]) + pc[1] + rc[1], 0);
    btn = 2'b00;
    run(30);
    chk("cp_press_edge", pe[0], e0 + 6);
    chk("cp_press_cnt", pc[0], 1);
    chk("cp_rel_edge", re[0], e0 + 26);
    chk("cp_long_none", lc[0], 0);

    // bounce: 1,0,1,0 every 2 clk then hold 1
    align(); clr(); e0 = e;
    btn = 2'b01; run(2);
    btn = 2'b00; run(2);
    btn = 2'b01; run(2);
    btn = 2'b00; run(2);
    btn = 2'b01; run(8);
    chk("bn_press_cnt", pc[0], 1);
    chk("bn_press_edge", pe[0], e0 + 14);
    chk("bn_rel_none", rc[0], 0);
    btn = 2'b00;
    run(30);
    chk("bn_rel_cnt", rc[0], 1);

    // long press with auto-repeat on channel 1
    align(); clr(); e0 = e; btn = 2'b10;
    run(80);
    btn = 2'b00;
    run(40);
    chk("lr_long_cnt", lc[1], 1);
    chk("lr_long_edge", le[1], e0 + 30);
    chk("lr_rep_first", qf[1], e0 + 50);
    chk("lr_rep_cnt", qc[1], 2);
    chk("lr_rel_edge", re[1], e0 + 86);
    chk("lr_rel_cnt", rc[1], 1);
    chk("lr_ch0_quiet", pc[0] + lc[0] + qc[0], 0);
    chk("lr_nr_long", nlc[1], 1);
    chk("lr_nr_rep", nqc[1], 0);

    // short press, 15 clk
    align(); clr(); e0 = e; btn = 2'b01;
    run(15);
    btn = 2'b00;
    run(30);
    chk("sp_press_cnt", pc[0], 1);
    chk("sp_rel_edge", re[0], e0 + 21);
    chk("sp_long_none", lc[0], 0);

    // debounced fall lands on the 3rd tick after the rise
    align(); clr(); e0 = e; btn = 2'b01;
    run(24);
    btn = 2'b00;
    run(30);
    chk("fc_rel_edge", re[0], e0 + 30);
    chk("fc_long_none", lc[0] + nlc[0], 0);

    // async reset while in REPEAT, button kept high
    align(); clr(); e0 = e; btn = 2'b01;
    run(55);
    chk("rs_pre_rep", qc[0], 1);
    chk("rs_pre_level", int'(level[0]), 1);
    chk("rs_nr_long", nlc[0], 1);
    chk("rs_nr_rep", nqc[0], 0);
    rst = 1'b1;
    #1;
    chk("rs_async_outs", int'({level, press, rel, lng, rep, nlevel, npress, nrel, nlng, nrep}), 0);
    run(3);
    rst = 1'b0;
    r = e; clr();
    run(6);
    chk("rs_repress_edge", pe[0], r + 6);
    chk("rs_repress_cnt", pc[0], 1);
    run(60);
    chk("rs_long_edge", le[0], r + 32);
    chk("rs_rep_cnt", qc[0], 1);
    chk("rs_nr_long2", nlc[0], 1);
    chk("rs_nr_rep2", nqc[0], 0);
    btn = 2'b00;
    run(20);
    chk("rs_rel_cnt", rc[0], 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
